mem_unified_bytelane: RTL and testbench

//  Next-generation unified instruction/data memory for the pipelined CPU, parametrised in address window and depth.
//  - Instruction read port: combinational.
//  - Data port: byte/half/word loads and stores with sign extension, plus alignment and bounds checking.
//  - String-print engine: clocked FSM that streams NUL-terminated strings one character per cycle.

---
 rtl/mem_unified_bytelane.sv | 168 ++++++++++++++++
 tb/tb_mem_unified_bytelane.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_unified_bytelane.sv
// Unified instruction/data memory: combinational instruction and data reads,
// byte-lane stores with fault checking, and a clocked NUL-terminated string print engine.
module mem_unified_bytelane #(
  parameter logic [31:0] ADDR_LO   = 32'h0040_0000,
  parameter logic [31:0] ADDR_HI   = 32'h0041_FFFF,
  parameter              INIT_FILE = "",
  parameter int unsigned MAX_STR   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_pc,
  output logic [31:0] instr_out,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic        data_signed,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic [1:0]  data_fault,
  output logic        fault_sticky,
  input  logic        print_start,
  input  logic [31:0] print_addr,
  output logic        print_busy,
  output logic        print_valid,
  output logic [7:0]  print_char,
  output logic        print_done
);

  localparam int unsigned DEPTH = (ADDR_HI - ADDR_LO + 32'd1) / 32'd4;
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(MAX_STR + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [31:0] r_mem [DEPTH];

  // 33-bit end address so an access straddling 2^32 cannot wrap back into range
  function automatic logic in_range(input logic [31:0] a, input logic [2:0] nbytes);
    logic [32:0] last;
    last = {1'b0, a} + 33'(nbytes) - 33'd1;
    return (a >= ADDR_LO) && (last <= {1'b0, ADDR_HI});
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - ADDR_LO) >> 2);
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign instr_out = in_range(instr_pc, 3'd1) ? r_mem[word_idx(instr_pc)] : '0;

  logic [2:0]  w_nbytes;
  logic        w_misalign;
  logic [1:0]  w_fault_raw;
  logic        w_ok;
  logic [31:0] w_dword;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;
  logic [31:0] w_wd;

  always_comb begin
    w_nbytes   = 3'd4;
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wd       = data_wdata;
    case (data_size)
      2'b00: begin
        w_nbytes = 3'd1;
        w_be     = 4'b0001 << data_addr[1:0];
        w_wd     = {4{data_wdata[7:0]}};
      end
      2'b01: begin
        w_nbytes   = 3'd2;
        w_misalign = data_addr[0];
        w_be       = data_addr[1] ? 4'b1100 : 4'b0011;
        w_wd       = {2{data_wdata[15:0]}};
      end
      2'b10:   w_misalign = |data_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_fault_raw = {~in_range(data_addr, w_nbytes), w_misalign};
  assign data_fault  = data_req ? w_fault_raw : 2'b00;
  assign w_ok        = data_req & ~|w_fault_raw;
  assign w_dword     = r_mem[word_idx(data_addr)];
  assign w_byte      = lane(w_dword, data_addr[1:0]);
  assign w_half      = data_addr[1] ? w_dword[31:16] : w_dword[15:0];

  always_comb begin
    data_rdata = '0;
    if (w_ok && !data_we) begin
      case (data_size)
        2'b00:   data_rdata = {{24{data_signed & w_byte[7]}}, w_byte};
        2'b01:   data_rdata = {{16{data_signed & w_half[15]}}, w_half};
        default: data_rdata = w_dword;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_ok && data_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[word_idx(data_addr)][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  logic r_fault_sticky;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_fault_sticky <= 1'b0;
    else if (data_req && |w_fault_raw) r_fault_sticky <= 1'b1;
  end
  assign fault_sticky = r_fault_sticky;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [7:0]  w_pbyte;
  logic        w_pstop;

  assign w_pbyte = lane(r_mem[word_idx(r_ptr)], r_ptr[1:0]);
  assign w_pstop = !in_range(r_ptr, 3'd1) || (w_pbyte == 8'h00) || (r_cnt == CW'(MAX_STR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (print_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_pstop)     w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (r_state == S_IDLE && print_start) begin
      r_ptr <= print_addr;
      r_cnt <= '0;
    end else if (r_state == S_RUN && !w_pstop) begin
      r_ptr <= r_ptr + 32'd1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    print_busy  = (r_state == S_RUN);
    print_valid = (r_state == S_RUN) && !w_pstop;
    print_char  = print_valid ? w_pbyte : 8'h00;
    print_done  = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_mem_unified_bytelane.sv
// Directed bench for mem_unified_bytelane: data port, faults, print engine, reset abort.
module tb_mem_unified_bytelane;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_pc = '0;
  logic        data_req = 1'b0, data_we = 1'b0, data_signed = 1'b0;
  logic [1:0]  data_size = 2'b10;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        print_start = 1'b0, print_start4 = 1'b0;
  logic [31:0] print_addr = '0;

  logic [31:0] instr_out, data_rdata, instr_out4, data_rdata4;
  logic [1:0]  data_fault, data_fault4;
  logic        fault_sticky, print_busy, print_valid, print_done;
  logic        fault_sticky4, print_busy4, print_valid4, print_done4;
  logic [7:0]  print_char, print_char4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_unified_bytelane u_dut (
    .clk(clk), .rst_n(rst_n), .instr_pc(instr_pc), .instr_out(instr_out),
    .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_signed(data_signed),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_fault(data_fault), .fault_sticky(fault_sticky),
    .print_start(print_start), .print_addr(print_addr), .print_busy(print_busy),
    .print_valid(print_valid), .print_char(print_char), .print_done(print_done)
  );

  mem_unified_bytelane #(.MAX_STR(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .instr_pc(instr_pc), .instr_out(instr_out4),
    .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_signed(data_signed),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata4),
    .data_fault(data_fault4), .fault_sticky(fault_sticky4),
    .print_start(print_start4), .print_addr(print_addr), .print_busy(print_busy4),
    .print_valid(print_valid4), .print_char(print_char4), .print_done(print_done4)
  );

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b1; data_addr = a; data_size = sz; data_wdata = d;
    @(posedge clk); #1;
    data_req = 1'b0; data_we = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sgn,
                      output logic [31:0] rd, output logic [1:0] flt);
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b0; data_addr = a; data_size = sz; data_signed = sgn;
    #1;
    rd = data_rdata; flt = data_fault;
    data_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({print_busy, print_valid, print_done, fault_sticky} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {print_busy, print_valid, print_done, fault_sticky});
    end
    checks++;
    if (print_char !== 8'h00) begin
      failures++; $display("FAIL reset_char got=%h exp=00", print_char);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_lanes;
    logic [31:0] rd; logic [1:0] f;
    store(32'h0040_0010, 2'b10, 32'hDEAD_BEEF);
    load(32'h0040_0013, 2'b00, 1'b1, rd, f);
    checks++;
    if (rd !== 32'hFFFF_FFDE || f !== 2'b00) begin
      failures++; $display("FAIL lb_signed got=%h/%b exp=ffffffde/00", rd, f);
    end
    load(32'h0040_0010, 2'b00, 1'b0, rd, f);
    checks++;
    if (rd !== 32'h0000_00EF) begin failures++; $display("FAIL lbu got=%h exp=000000ef", rd); end
    load(32'h0040_0012, 2'b01, 1'b1, rd, f);
    checks++;
    if (rd !== 32'hFFFF_DEAD) begin failures++; $display("FAIL lh_signed got=%h exp=ffffdead", rd); end
    load(32'h0040_0010, 2'b01, 1'b0, rd, f);
    checks++;
    if (rd !== 32'h0000_BEEF) begin failures++; $display("FAIL lhu got=%h exp=0000beef", rd); end
    instr_pc = 32'h0040_0012; #1;
    checks++;
    if (instr_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL instr_word got=%h exp=deadbeef", instr_out); end
  endtask

  task automatic test_subword_store;
    logic [31:0] rd; logic [1:0] f;
    store(32'h0040_0012, 2'b01, 32'hFFFF_1234);
    load(32'h0040_0010, 2'b10, 1'b0, rd, f);
    checks++;
    if (rd !== 32'h1234_BEEF) begin failures++; $display("FAIL sh_merge got=%h exp=1234beef", rd); end
    store(32'h0040_0011, 2'b00, 32'hAAAA_AA55);
    load(32'h0040_0010, 2'b10, 1'b0, rd, f);
    checks++;
    if (rd !== 32'h1234_55EF) begin failures++; $display("FAIL sb_merge got=%h exp=123455ef", rd); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic [1:0] f;
    store(32'h0040_0000, 2'b10, 32'hA5A5_A5A5);
    checks++;
    if (fault_sticky !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%b exp=0", fault_sticky); end
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b0; data_size = 2'b10; data_addr = 32'h0040_0002; #1;
    checks++;
    if (data_fault !== 2'b01 || data_rdata !== 32'h0) begin
      failures++; $display("FAIL lw_misaligned got=%b/%h exp=01/00000000", data_fault, data_rdata);
    end
    @(posedge clk); #1;
    data_req = 1'b0;
    checks++;
    if (fault_sticky !== 1'b1) begin failures++; $display("FAIL sticky_set got=%b exp=1", fault_sticky); end
    store(32'h0040_0002, 2'b10, 32'hFFFF_FFFF);
    load(32'h0040_0000, 2'b10, 1'b0, rd, f);
    checks++;
    if (rd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL misaligned_no_write got=%h exp=a5a5a5a5", rd); end
    load(32'h0040_0000, 2'b11, 1'b0, rd, f);
    checks++;
    if (f !== 2'b01 || rd !== 32'h0) begin failures++; $display("FAIL size11 got=%b/%h exp=01/00000000", f, rd); end
  endtask

  task automatic test_bounds;
    logic [31:0] rd; logic [1:0] f;
    store(32'h0042_0000, 2'b00, 32'h0000_0077);
    load(32'h0040_0000, 2'b10, 1'b0, rd, f);
    checks++;
    if (rd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL oob_no_write got=%h exp=a5a5a5a5", rd); end
    load(32'h0042_0000, 2'b00, 1'b0, rd, f);
    checks++;
    if (f !== 2'b10 || rd !== 32'h0) begin failures++; $display("FAIL lb_above got=%b/%h exp=10/00000000", f, rd); end
    load(32'h0041_FFFF, 2'b01, 1'b0, rd, f);
    checks++;
    if (f !== 2'b11) begin failures++; $display("FAIL lh_top_edge got=%b exp=11", f); end
    load(32'h0041_FFFC, 2'b10, 1'b0, rd, f);
    checks++;
    if (f !== 2'b00) begin failures++; $display("FAIL lw_last_word got=%b exp=00", f); end
    load(32'h003F_FFFF, 2'b00, 1'b0, rd, f);
    checks++;
    if (f !== 2'b10) begin failures++; $display("FAIL lb_below got=%b exp=10", f); end
    @(negedge clk);
    data_req = 1'b0; data_addr = 32'h0042_0000; instr_pc = 32'h0042_0000; #1;
    checks++;
    if (data_fault !== 2'b00 || instr_out !== 32'h0) begin
      failures++; $display("FAIL idle_fault_instr_oob got=%b/%h exp=00/00000000", data_fault, instr_out);
    end
  endtask

  task automatic test_same_cycle;
    store(32'h0040_0020, 2'b10, 32'hCAFE_F00D);
    @(negedge clk);
    instr_pc = 32'h0040_0020;
    data_req = 1'b1; data_we = 1'b1; data_size = 2'b10; data_addr = 32'h0040_0020; data_wdata = 32'h1122_3344;
    #1;
    checks++;
    if (instr_out !== 32'hCAFE_F00D) begin failures++; $display("FAIL same_cycle_old got=%h exp=cafef00d", instr_out); end
    @(posedge clk); #1;
    data_req = 1'b0; data_we = 1'b0;
    checks++;
    if (instr_out !== 32'h1122_3344) begin failures++; $display("FAIL next_cycle_new got=%h exp=11223344", instr_out); end
  endtask

  task automatic test_print_hi;
    logic       ev [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] ec [6] = '{8'h48, 8'h69, 8'h21, 8'h00, 8'h00, 8'h00};
    logic       ed [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       eb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    store(32'h0041_0040, 2'b10, 32'h0021_6948);
    @(negedge clk);
    print_addr = 32'h0041_0040; print_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      print_start = 1'b0;
      checks++;
      if (print_valid !== ev[i] || print_char !== ec[i] || print_done !== ed[i] || print_busy !== eb[i]) begin
        failures++;
        $display("FAIL print_hi cyc=%0d got v=%b c=%h d=%b b=%b exp v=%b c=%h d=%b b=%b",
                 i, print_valid, print_char, print_done, print_busy, ev[i], ec[i], ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_max_str;
    int n_main = 0, n4 = 0, d_main = 0, d4 = 0;
    logic [31:0] acc4 = '0;
    store(32'h0041_0100, 2'b10, 32'h4443_4241);
    store(32'h0041_0104, 2'b10, 32'h4847_4645);
    store(32'h0041_0108, 2'b10, 32'h0000_4A49);
    @(negedge clk);
    print_addr = 32'h0041_0100; print_start = 1'b1; print_start4 = 1'b1;
    @(posedge clk); #1;
    print_start = 1'b0; print_start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      print_start4 = (i == 1);
      print_addr   = (i == 1) ? 32'h0041_0040 : 32'h0041_0100;
      #1;
      if (print_valid) n_main++;
      if (print_done) d_main++;
      if (print_valid4) begin n4++; acc4 = {acc4[23:0], print_char4}; end
      if (print_done4) d4++;
    end
    print_start4 = 1'b0;
    checks++;
    if (n4 !== 4 || d4 !== 1 || acc4 !== 32'h4142_4344) begin
      failures++; $display("FAIL max_str4 got n=%0d d=%0d s=%h exp n=4 d=1 s=41424344", n4, d4, acc4);
    end
    checks++;
    if (n_main !== 10 || d_main !== 1) begin
      failures++; $display("FAIL ten_chars got n=%0d d=%0d exp n=10 d=1", n_main, d_main);
    end
    checks++;
    if (print_busy4 !== 1'b0 || print_busy !== 1'b0) begin
      failures++; $display("FAIL print_idle_after got=%b%b exp=00", print_busy, print_busy4);
    end
  endtask

  task automatic test_reset_mid_print;
    logic [31:0] rd; logic [1:0] f;
    int seen_done = 0;
    @(negedge clk);
    print_addr = 32'h0041_0100; print_start = 1'b1;
    @(negedge clk); print_start = 1'b0;
    @(negedge clk);
    checks++;
    if (print_valid !== 1'b1 || print_char !== 8'h42) begin
      failures++; $display("FAIL pre_reset_char got=%b/%h exp=1/42", print_valid, print_char);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (print_busy !== 1'b0 || print_valid !== 1'b0) begin
      failures++; $display("FAIL reset_abort got busy=%b valid=%b exp 0 0", print_busy, print_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      #1;
      if (print_done || print_busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin failures++; $display("FAIL no_done_after_abort got=%0d exp=0", seen_done); end
    load(32'h0040_0010, 2'b10, 1'b0, rd, f);
    checks++;
    if (rd !== 32'h1234_55EF) begin failures++; $display("FAIL mem_retained got=%h exp=123455ef", rd); end
    checks++;
    if (fault_sticky !== 1'b0) begin failures++; $display("FAIL sticky_reset got=%b exp=0", fault_sticky); end
  endtask

  initial begin
    test_reset();
    test_word_lanes();
    test_subword_store();
    test_misaligned();
    test_bounds();
    test_same_cycle();
    test_print_hi();
    test_max_str();
    test_reset_mid_print();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
